nem_ohmux_sel_ctrl: RTL and testbench

NEM_OHMUX_SEL_CTRL -- requirements
Module: nem_ohmux_sel_ctrl

---
 rtl/nem_ohmux_sel_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_nem_ohmux_sel_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nem_ohmux_sel_ctrl.sv
// -----------------------------------------------------------------------------
// nem_ohmux_sel_ctrl
// Break-before-make sequencer for the one-hot relay select lines of a
// NEM one-hot mux. It accepts a request to switch to select index i, or to
// turn everything off. Before a different select is made it always drops
// every select for DEAD_CYC cycles. After a select asserts it optionally
// waits SETTLE_CYC cycles for relay pull-in, then reports completion.
//
// Configuration macro: NEM_OHSEL_SETTLE_EN
//   defined   : MAKE_SETTLE waits SETTLE_CYC cycles before HOLD/DONE.
//   undefined : SETTLE_CYC is ignored. HOLD and DONE coincide with the
//               cycle on which S becomes one-hot.
//
// Parameters
//   N_SEL      number of one-hot select lines
//   DEAD_CYC   dead time (all selects low) in cycles, >= 1
//   SETTLE_CYC relay settle time in cycles, >= 1
//
// Ports
//   CP       in   clock, rising edge
//   RST      in   synchronous active-high reset
//   REQ      in   request valid
//   REQ_OFF  in   with REQ: turn all selects off (SEL_IDX ignored)
//   SEL_IDX  in   requested select index
//   RDY      out  request accepted this cycle if REQ=1 (OFF or HOLD)
//   DONE     out  one-cycle pulse when the requested state is stable
//   ERR      out  one-cycle pulse for an accepted out-of-range index
//   S        out  one-hot (or all-zero) relay select drive
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module nem_ohmux_sel_ctrl #(
    parameter int N_SEL      = 2,
    parameter int DEAD_CYC   = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic                                         CP,
    input  logic                                         RST,
    input  logic                                         REQ,
    input  logic                                         REQ_OFF,
    input  logic [((N_SEL > 1) ? $clog2(N_SEL) : 1)-1:0] SEL_IDX,
    output logic                                         RDY,
    output logic                                         DONE,
    output logic                                         ERR,
    output logic [N_SEL-1:0]                             S
);

    localparam int IW      = (N_SEL > 1) ? $clog2(N_SEL) : 1;
    localparam int MAX_CYC = (DEAD_CYC > SETTLE_CYC) ? DEAD_CYC : SETTLE_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Counters load "cycles - 1" and the phase ends when they read zero.
    localparam logic [CW-1:0] CNT_DEAD   = CW'(DEAD_CYC - 1);
`ifdef NEM_OHSEL_SETTLE_EN
    localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE_CYC - 1);
`endif
    localparam logic [IW:0]   N_SEL_W    = (IW + 1)'(N_SEL);

    typedef enum logic [1:0] {
        ST_OFF         = 2'd0,
        ST_BREAK       = 2'd1,
        ST_MAKE_SETTLE = 2'd2,
        ST_HOLD        = 2'd3
    } state_t;

    state_t              r_state;
    logic [N_SEL-1:0]    r_s;
    logic                r_rdy;
    logic                r_done;
    logic                r_err;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic                r_to_off;   // current BREAK ends in OFF, not in a new select

    logic                w_idx_bad;
    logic                w_idx_same;

    // Decode an index into a one-hot select vector. Loop form keeps it legal
    // for any N_SEL, including N_SEL=1 and non-power-of-two sizes.
    function automatic logic [N_SEL-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_SEL-1:0] v;
        v = '0;
        for (int k = 0; k < N_SEL; k++) begin
            if (idx == IW'(k)) begin
                v[k] = 1'b1;
            end else begin
                v[k] = 1'b0;
            end
        end
        return v;
    endfunction

    assign w_idx_bad  = ({1'b0, SEL_IDX} >= N_SEL_W);
    assign w_idx_same = (SEL_IDX == r_idx);

    // Sequencer: state, select drive, counter and status pulses.
    always_ff @(posedge CP) begin
        if (RST) begin
            r_state  <= ST_OFF;
            r_s      <= '0;
            r_rdy    <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_to_off <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_OFF: begin
                    if (REQ) begin
                        if (REQ_OFF) begin
                            r_done <= 1'b1;
                        end else if (w_idx_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            // Nothing is made, so no dead time is needed.
                            r_idx <= SEL_IDX;
                            r_s   <= onehot(SEL_IDX);
`ifdef NEM_OHSEL_SETTLE_EN
                            r_state <= ST_MAKE_SETTLE;
                            r_rdy   <= 1'b0;
                            r_cnt   <= CNT_SETTLE;
`else
                            r_state <= ST_HOLD;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    if (REQ) begin
                        if (REQ_OFF) begin
                            r_s      <= '0;
                            r_state  <= ST_BREAK;
                            r_rdy    <= 1'b0;
                            r_cnt    <= CNT_DEAD;
                            r_to_off <= 1'b1;
                        end else if (w_idx_bad) begin
                            r_err <= 1'b1;
                        end else if (w_idx_same) begin
                            r_done <= 1'b1;
                        end else begin
                            // Target index is latched now; SEL_IDX is not
                            // looked at again until the next accept.
                            r_idx    <= SEL_IDX;
                            r_s      <= '0;
                            r_state  <= ST_BREAK;
                            r_rdy    <= 1'b0;
                            r_cnt    <= CNT_DEAD;
                            r_to_off <= 1'b0;
                        end
                    end
                end
                ST_BREAK: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (r_to_off) begin
                        r_state <= ST_OFF;
                        r_rdy   <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_s <= onehot(r_idx);
`ifdef NEM_OHSEL_SETTLE_EN
                        r_state <= ST_MAKE_SETTLE;
                        r_cnt   <= CNT_SETTLE;
`else
                        r_state <= ST_HOLD;
                        r_rdy   <= 1'b1;
                        r_done  <= 1'b1;
`endif
                    end
                end
                ST_MAKE_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_state <= ST_HOLD;
                        r_rdy   <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to the safe all-off state.
                    r_state <= ST_OFF;
                    r_s     <= '0;
                    r_rdy   <= 1'b1;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign S    = r_s;
    assign RDY  = r_rdy;
    assign DONE = r_done;
    assign ERR  = r_err;

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for nem_ohmux_sel_ctrl. Two instances share the control inputs:
// u_dut2 (N_SEL=2) and u_dut3 (N_SEL=3, so out-of-range indices exist).
// The reference model keeps, per instance, the currently made index and a
// queue of the outputs promised for the coming cycles. An accepted request
// appends its whole timeline (dead cycles, settle cycles, completion cycle)
// to that queue. Follows the same NEM_OHSEL_SETTLE_EN setting as the RTL.
// -----------------------------------------------------------------------------
module tb_nem_ohmux_sel_ctrl;

    localparam int DEAD   = 4;
    localparam int SETTLE = 8;
`ifdef NEM_OHSEL_SETTLE_EN
    localparam bit SETTLE_EN = 1'b1;
`else
    localparam bit SETTLE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] s;
        logic       rdy;
        logic       done;
        logic       err;
    } exp_t;

    logic       CP = 1'b0;
    logic       RST = 1'b1;
    logic       REQ = 1'b0;
    logic       REQ_OFF = 1'b0;
    logic       sel2 = 1'b0;
    logic [1:0] sel3 = 2'b00;

    logic       rdy2, done2, err2;
    logic [1:0] s2;
    logic       rdy3, done3, err3;
    logic [2:0] s3;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   cur [2];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 CP = ~CP;

    nem_ohmux_sel_ctrl #(.N_SEL(2), .DEAD_CYC(DEAD), .SETTLE_CYC(SETTLE)) u_dut2 (
        .CP(CP), .RST(RST), .REQ(REQ), .REQ_OFF(REQ_OFF), .SEL_IDX(sel2),
        .RDY(rdy2), .DONE(done2), .ERR(err2), .S(s2)
    );

    nem_ohmux_sel_ctrl #(.N_SEL(3), .DEAD_CYC(DEAD), .SETTLE_CYC(SETTLE)) u_dut3 (
        .CP(CP), .RST(RST), .REQ(REQ), .REQ_OFF(REQ_OFF), .SEL_IDX(sel3),
        .RDY(rdy3), .DONE(done3), .ERR(err3), .S(s3)
    );

    // Compare one observed value against its expectation and count it.
    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h, want %h ({s,rdy,done,err})", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [2:0] oh(input int i);
        logic [2:0] v;
        v = 3'b000;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic exp_t mk(input logic [2:0] s, input logic r, input logic dn, input logic er);
        exp_t e;
        e.s = s; e.rdy = r; e.done = dn; e.err = er;
        return e;
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Append the full output timeline of one accepted request.
    task automatic plan(input int d, input bit off, input int idx);
        int n;
        n = (d == 0) ? 2 : 3;
        if (off) begin
            if (cur[d] >= 0) begin
                for (int k = 0; k < DEAD; k++) push(d, mk(3'b000, 1'b0, 1'b0, 1'b0));
            end
            push(d, mk(3'b000, 1'b1, 1'b1, 1'b0));
            cur[d] = -1;
        end else if (idx >= n) begin
            push(d, mk(oh(cur[d]), 1'b1, 1'b0, 1'b1));
        end else if (idx == cur[d]) begin
            push(d, mk(oh(idx), 1'b1, 1'b1, 1'b0));
        end else begin
            if (cur[d] >= 0) begin
                for (int k = 0; k < DEAD; k++) push(d, mk(3'b000, 1'b0, 1'b0, 1'b0));
            end
            if (SETTLE_EN) begin
                for (int k = 0; k < SETTLE; k++) push(d, mk(oh(idx), 1'b0, 1'b0, 1'b0));
            end
            push(d, mk(oh(idx), 1'b1, 1'b1, 1'b0));
            cur[d] = idx;
        end
    endtask

    // Expected outputs after the coming edge for instance d.
    task automatic model_step(input int d, input bit rst, input bit req, input bit off,
                              input int idx, output exp_t e);
        int len;
        if (rst) begin
            if (d == 0) q0.delete(); else q1.delete();
            cur[d] = -1;
            e = mk(3'b000, 1'b1, 1'b0, 1'b0);
        end else begin
            len = (d == 0) ? q0.size() : q1.size();
            // An empty queue means the instance is idle now, i.e. ready.
            if (len == 0 && req) plan(d, off, idx);
            len = (d == 0) ? q0.size() : q1.size();
            if (len != 0) begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
            end else begin
                e = mk(oh(cur[d]), 1'b1, 1'b0, 1'b0);
            end
        end
    endtask

    // Apply one cycle of stimulus and check both instances after the edge.
    task automatic cycle(input bit rst, input bit req, input bit off, input int i2, input int i3);
        exp_t e2, e3;
        RST     = rst;
        REQ     = req;
        REQ_OFF = off;
        sel2    = 1'(i2);
        sel3    = 2'(i3);
        model_step(0, rst, req, off, i2, e2);
        model_step(1, rst, req, off, i3, e3);
        @(posedge CP);
        @(negedge CP);
        check_val("dut2", {3'b000, s2, rdy2, done2, err2}, {2'b00, e2});
        check_val("dut3", {2'b00, s3, rdy3, done3, err3}, {2'b00, e3});
        check_val("onehot2", {7'd0, ($countones(s2) <= 1)}, 8'd1);
        check_val("onehot3", {7'd0, ($countones(s3) <= 1)}, 8'd1);
    endtask

    // Idle cycles with a wandering SEL_IDX that must be ignored.
    task automatic idle(input int k);
        for (int j = 0; j < k; j++) cycle(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    endtask

    initial begin
        cur[0] = -1;
        cur[1] = -1;
        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 1'b1, 1'b0, 1, 1);   // RST wins over REQ
        idle(2);
        // OFF -> select 1, settle, DONE
        cycle(1'b0, 1'b1, 1'b0, 1, 1);
        idle(12);
        // HOLD 1 -> select 0 via break-before-make; SEL_IDX wanders meanwhile
        cycle(1'b0, 1'b1, 1'b0, 0, 0);
        idle(16);
        // Same index again: immediate DONE
        cycle(1'b0, 1'b1, 1'b0, 0, 0);
        idle(3);
        // Out-of-range on the 3-wide instance: ERR only
        cycle(1'b0, 1'b1, 1'b0, 0, 3);
        idle(3);
        // Change select, then RST during the third BREAK cycle
        cycle(1'b0, 1'b1, 1'b0, 1, 2);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        idle(3);
        // OFF request from OFF, with an out-of-range index that must not ERR
        cycle(1'b0, 1'b1, 1'b1, 1, 3);
        idle(2);
        // Make a select, then turn it off through BREAK
        cycle(1'b0, 1'b1, 1'b0, 0, 2);
        idle(12);
        cycle(1'b0, 1'b1, 1'b1, 1, 3);
        idle(8);
        // Randomised traffic
        for (int t = 0; t < 4000; t++) begin
            cycle(($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0),
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
